// File: rtl/aftab_shift_pkg.sv
// Shared definitions for the AFTAB serial shift units: controller state
// encoding used by the right-shift unit (and mirrored by the left-shift path).
package aftab_shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } shift_state_e;

endpackage : aftab_shift_pkg

// File: rtl/aftab_shift_right_register.sv
// Right-shifting data register with parallel load and serial in/out.
// Shared by the serial shift unit and the multiplier path.
// Priority: rst > init > Ld > sh_R_en > hold.
module aftab_shift_right_register #(
    parameter int size = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            init,
    input  logic            Ld,
    input  logic            sh_R_en,
    input  logic            serIn,
    input  logic [size-1:0] dataIn,
    output logic [size-1:0] dataOut,
    output logic            serOut
);

    // Register update: clear, load, shift right by one, or hold.
    // NOTE: non-blocking (<=) for every flop so all registers update from
    // pre-edge values; blocking here would create simulation order races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dataOut <= '0;
            serOut  <= 1'b0;
        end else if (init) begin
            dataOut <= '0;
            serOut  <= 1'b0;
        end else if (Ld) begin
            // A fresh operand has shifted nothing out yet.
            dataOut <= dataIn;
            serOut  <= 1'b0;
        end else if (sh_R_en) begin
            dataOut <= {serIn, dataOut[size-1:1]};
            serOut  <= dataOut[0];
        end
    end

endmodule : aftab_shift_right_register

// File: rtl/aftab_serial_shift_right_unit.sv
// Multi-cycle SRL/SRA unit: one bit per clock through a right-shift
// register, sequenced by a three-state controller with start/done handshake.
// shamtWidth must equal log2(size).
module aftab_serial_shift_right_unit
    import aftab_shift_pkg::*;
#(
    parameter int size       = 32,
    parameter int shamtWidth = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init,
    input  logic                  start,
    input  logic                  arith,
    input  logic [shamtWidth-1:0] shamt,
    input  logic [size-1:0]       dataIn,
    output logic                  ready,
    output logic                  done,
    output logic [size-1:0]       dataOut,
    output logic                  serOut
);

    shift_state_e          state_q, state_d;
    logic [shamtWidth-1:0] counter_q;
    logic                  fill_q;
    logic                  accept;
    logic                  shift_en;

    // Handshake outputs are pure state decodes: no path from start.
    assign ready    = (state_q == IDLE);
    assign done     = (state_q == DONE);
    assign accept   = ready && start;
    assign shift_en = (state_q == SHIFT);

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; init forces IDLE from any state.
    // NOTE: state_d gets a default before the case so every path assigns
    // it and no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (init) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:  if (start) state_d = (shamt != '0) ? SHIFT : DONE;
                // Exit on 1 rather than 0 so the counter never wraps.
                SHIFT: if (counter_q == shamtWidth'(1)) state_d = DONE;
                DONE:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Shift-amount down-counter and fill bit captured at load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter_q <= '0;
            fill_q    <= 1'b0;
        end else if (init) begin
            counter_q <= '0;
            fill_q    <= 1'b0;
        end else if (accept) begin
            counter_q <= shamt;
            fill_q    <= arith & dataIn[size-1];
        end else if (shift_en) begin
            counter_q <= counter_q - shamtWidth'(1);
        end
    end

    aftab_shift_right_register #(
        .size(size)
    ) u_shift_reg (
        .clk    (clk),
        .rst    (rst),
        .init   (init),
        .Ld     (accept),
        .sh_R_en(shift_en),
        .serIn  (fill_q),
        .dataIn (dataIn),
        .dataOut(dataOut),
        .serOut (serOut)
    );

endmodule : aftab_serial_shift_right_unit

// File: doc/aftab_serial_shift_right_unit.md
Name: aftab_serial_shift_right_unit

Overview:
Multi-cycle right-shift unit for the AFTAB datapath. It executes SRL/SRA (and SRLI/SRAI) one bit per clock. A right-shifting data register is driven by a small controller with start/done handshake. It mirrors the existing left-shift register path and lets the ALU drop a combinational barrel shifter.

Parameters:
size, 32, data width in bits
shamtWidth, 5, shift-amount width; must equal log2(size)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
init  input  1  synchronous clear; highest priority after rst
start  input  1  begin operation; accepted only when ready=1
arith  input  1  1=arithmetic (sign fill), 0=logical (zero fill); sampled with start
shamt  input  shamtWidth  shift amount; sampled with start
dataIn  input  size  operand; sampled with start
ready  output  1  unit idle, start will be accepted
done  output  1  one-cycle pulse: dataOut/serOut valid
dataOut  output  size  shift register contents / result
serOut  output  1  last bit shifted out of bit 0 (0 if shamt=0)

Behaviour:
- Reset (rst=1, async): state=IDLE, dataOut=0, serOut=0, done=0, ready=1, counter=0, fill=0.
- init=1 at a clock edge, in any state: same values as reset; overrides start and any in-progress shift.
- States:
  - IDLE: ready=1. On start:
    - load dataIn into the register; counter<=shamt; fill<=arith & dataIn[size-1]; serOut<=0.
    - next state: SHIFT if shamt!=0, else DONE.
  - SHIFT: ready=0. Each cycle: dataOut<={fill, dataOut[size-1:1]}; serOut<=dataOut[0]; counter<=counter-1. When counter==1 this cycle, next state is DONE.
  - DONE: done=1, ready=0 for exactly one cycle; register holds; next state is IDLE.
- Latency: start sampled at edge 0 -> done high during cycle shamt+1. shamt=0 -> done high in cycle 1 with dataOut=dataIn.
- dataOut and serOut hold after DONE until the next accepted start, init, or rst.
- start while ready=0 is ignored; no queuing. arith, shamt and dataIn are don't-care except at the accepting edge.
- Fill bit is captured at load; later dataIn changes do not affect it.
- Counter never wraps: the SHIFT exit condition is checked on counter==1. The maximum shamt (size-1) takes size-1 shift cycles.
- done and ready are registered or decoded from state only; no combinational path from start.

Decomposition:
- Shared package aftab_shift_pkg: state encoding constants (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10).
- Sub-module aftab_shift_right_register #(size). Ports: dataIn, sh_R_en, init, serIn, Ld, clk, rst, dataOut, serOut.
  - Priority order: rst > init > Ld > sh_R_en > hold.
  - Shift operation: dataOut<={serIn, dataOut[size-1:1]}; serOut<=dataOut[0].
  - Reusable by the multiplier path.
- The top level holds the FSM, the shamt down-counter and the fill flop.

Test Plan:
- SRL: dataIn=0x80000000, shamt=4, arith=0 -> done in cycle 5, dataOut=0x08000000, serOut=0, ready back to 1 in cycle 6.
- SRA: dataIn=0x80000000, shamt=4, arith=1 -> dataOut=0xF8000000. SRA dataIn=0xFFFFFFF5, shamt=31 -> done in cycle 32, dataOut=0xFFFFFFFF, serOut=1.
- shamt=0: dataIn=0x12345678 -> done in cycle 1, dataOut=0x12345678, serOut=0. SRL 0x00000003 by 1 -> dataOut=0x00000001, serOut=1.
- Busy rejection: start 0xF0000000 >>3, then start again with 0x1 >>1 in cycle 2 -> second start ignored; result 0x1E000000 in cycle 4.
- init pulse in cycle 2 of a 10-bit shift -> next cycle IDLE, dataOut=0, serOut=0, no done pulse. A new start is then accepted normally.
- Async rst asserted mid-SHIFT between clock edges -> outputs zero immediately, ready=1. After release, SRA 0xC0000000 >>1 gives 0xE0000000.
